axi_grid_sni_rd: RTL and testbench
==================================

Name: axi_grid_sni_rd

Overview:
Read-path slave network interface: accepts AXI AR from a local master, decodes the address to a destination grid node and forwards it as a tagged grid AR flit. Returns grid R flits to AXI R with the original AXI ID restored.
Tracks outstanding reads in a slot table; the slot index is the grid tag, so out-of-order completion is allowed. Unmapped addresses get a locally generated DECERR burst. Sits between an AXI master port and the grid router read channels.

Parameters:
ADDR_WIDTH, 32, AXI/grid address width
DATA_WIDTH, 64, R data width
ID_WIDTH, 4, AXI ID width
GRID_ID_WIDTH, 4, grid node id width
NI_ID, 0, this node's grid id, sent as g_ar_src_o
NUM_REGIONS, 4, address map entries (1..16)
REGION_BASE, 0, packed NUM_REGIONS x ADDR_WIDTH, region base addresses
REGION_MASK, 0, packed NUM_REGIONS x ADDR_WIDTH, region match masks
REGION_DEST, 0, packed NUM_REGIONS x GRID_ID_WIDTH, destination grid id per region
MAX_OUTSTANDING, 8, slot table depth (power of 2, >=2); TAG_W = clog2(MAX_OUTSTANDING)

Ports:
clk_i  in  1  clock
arst_ni  in  1  async active-low reset
s_ar_valid_i/s_ar_ready_o  in/out  1  AXI AR handshake
s_ar_id_i  in  ID_WIDTH  AXI AR id
s_ar_addr_i  in  ADDR_WIDTH  AXI AR address
s_ar_len_i  in  8  AXI AR len
s_ar_size_i  in  3  AXI AR size
s_ar_burst_i  in  2  AXI AR burst
s_r_valid_o/s_r_ready_i  out/in  1  AXI R handshake
s_r_id_o  out  ID_WIDTH  R id
s_r_data_o  out  DATA_WIDTH  R data
s_r_resp_o  out  2  R resp
s_r_last_o  out  1  R last
g_ar_valid_o/g_ar_ready_i  out/in  1  grid AR handshake
g_ar_dst_o  out  GRID_ID_WIDTH  destination node
g_ar_src_o  out  GRID_ID_WIDTH  always NI_ID
g_ar_tag_o  out  TAG_W  slot index
g_ar_addr_o, g_ar_len_o, g_ar_size_o, g_ar_burst_o  out  as AXI  pass-through AR fields
g_r_valid_i/g_r_ready_o  in/out  1  grid R handshake
g_r_tag_i  in  TAG_W  returning slot
g_r_data_i, g_r_resp_i, g_r_last_i  in  DATA_WIDTH/2/1  grid R payload
outstanding_o  out  clog2(MAX_OUTSTANDING+1)  valid slot count
err_spurious_o  out  1  one-cycle pulse on R flit with unallocated tag

Behaviour:
- Reset (async, active-low): all slot valid bits 0, error FSM ERR_IDLE, R owner NONE. Outputs: s_ar_ready_o 0, g_ar_valid_o 0, s_r_valid_o 0, g_r_ready_o 0, outstanding_o 0, err_spurious_o 0.
- Decode (combinational): hit[i] = (s_ar_addr_i & MASK[i]) == BASE[i]; lowest index wins; g_ar_dst_o = REGION_DEST[winner].
- Mapped AR, zero added latency:
  - g_ar_valid_o = s_ar_valid_i & hit & free_slot; s_ar_ready_o = g_ar_ready_i & hit & free_slot.
  - On handshake: lowest free slot is marked valid and stores s_ar_id_i; g_ar_tag_o = that index.
  - No free slot: g_ar_valid_o = 0, s_ar_ready_o = 0.
- Unmapped AR: g_ar_valid_o = 0; s_ar_ready_o = 1 only in ERR_IDLE. Handshake captures id and len and moves the FSM to ERR_RESP.
- Error FSM:
  - ERR_RESP emits len+1 beats: resp = 2'b11, data = 0, last on final beat; beat counter is 8-bit.
  - On last-beat handshake it returns to ERR_IDLE. It never occupies a slot.
- R owner arbiter {NONE, GRID, ERR}:
  - From NONE, grid wins if g_r_valid_i; otherwise ERR if in ERR_RESP.
  - The owner is held until the last-beat handshake, so bursts never interleave; owner returns to NONE after that beat.
- Grid R routing:
  - s_r_id_o = table[g_r_tag_i].id; g_r_ready_o = s_r_ready_i while owner is GRID (or NONE and grid selected).
  - A g_r_last_i handshake frees the slot at the next clock edge.
- Spurious tag (slot not valid): g_r_ready_o = 1, beat dropped, no s_r output, err_spurious_o pulses high for one cycle. No owner is taken.
- Same-cycle free and allocate: allocation uses the registered free vector, so a slot freed this cycle is allocatable next cycle. outstanding_o reflects both events (net change -1, 0 or +1).
- s_r_valid_o, s_r_* payload and g_r_ready_o are combinational from owner state; no pipeline stage.
- Reset mid-burst: table cleared and FSM to ERR_IDLE. Late grid R flits after reset are treated as spurious.

Decomposition:
- Package axi_grid_sni_pkg: r_owner_e, err_state_e, slot_t {valid, id}, and an address-decode function.
- One sub-module, axi_grid_sni_slot_table: lowest-free allocate, free-by-tag, id lookup, count. Parametrised by MAX_OUTSTANDING and ID_WIDTH.

Test Plan:
- Region 1 = base 0x1000_0000 / mask 0xF000_0000 / dest 5; AR id=3, addr 0x1000_0040 -> g_ar dst=5, src=NI_ID, tag=0, outstanding_o=1. Then grid R tag=0, 4 beats -> 4 s_r beats with id=3, last on beat 4, outstanding_o=0.
- Issue 8 ARs without responses -> tags 0..7; 9th AR stalls (s_ar_ready_o=0). Return tag 5 last -> next cycle 9th AR is accepted with tag 5.
- Unmapped addr 0xF000_0000, len=3, id=9 -> 4 beats of resp=2'b11, id=9, last on beat 4; g_ar_valid_o never asserted.
- Grid R burst (tag 2, 2 beats) and error burst pending simultaneously -> grid burst completes first, then error burst; no interleave.
- Grid R with tag 6, slot 6 unallocated -> dropped, err_spurious_o high for 1 cycle, s_r_valid_o stays 0.
- Assert arst_ni low mid-error-burst -> s_r_valid_o=0 and outstanding_o=0 immediately. After release, a new AR is accepted with tag 0.

Source files
------------

// File: rtl/axi_grid_sni_pkg.sv
// Shared types and helpers for the grid read-path slave network interface.
//   r_owner_e   : which source currently drives the AXI R channel
//   err_state_e : state of the local DECERR responder
//   slot_t      : one entry of the outstanding-read table
//   region_match: single address-map entry comparison
package axi_grid_sni_pkg;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_GRID = 2'd1,
        R_ERR  = 2'd2
    } r_owner_e;

    typedef enum logic [0:0] {
        ERR_IDLE = 1'b0,
        ERR_RESP = 1'b1
    } err_state_e;

    // Widest AXI ID a slot can hold; narrower IDs are zero-extended.
    localparam int SLOT_ID_MAX = 16;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ID_MAX-1:0] id;
    } slot_t;

    localparam int         DEC_ADDR_MAX = 64;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    function automatic logic region_match(
        input logic [DEC_ADDR_MAX-1:0] addr,
        input logic [DEC_ADDR_MAX-1:0] base,
        input logic [DEC_ADDR_MAX-1:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/axi_grid_sni_slot_table.sv
// Outstanding-read slot table. The slot index is the grid tag.
//   alloc_en/alloc_id      : mark lowest free slot valid and store the AXI ID
//   alloc_ok/alloc_tag     : a free slot exists / its index (from registered state)
//   free_en/free_tag       : clear a slot at the next clock edge
//   lookup_tag             : tag of the returning R flit
//   lookup_valid/lookup_id : slot state and stored ID for that tag
//   count                  : number of valid slots
module axi_grid_sni_slot_table
    import axi_grid_sni_pkg::*;
#(
    parameter int  MAX_OUTSTANDING = 8,
    parameter int  ID_WIDTH        = 4,
    localparam int TAG_W           = $clog2(MAX_OUTSTANDING),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                alloc_en,
    input  logic [ID_WIDTH-1:0] alloc_id,
    output logic                alloc_ok,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                free_en,
    input  logic [TAG_W-1:0]    free_tag,
    input  logic [TAG_W-1:0]    lookup_tag,
    output logic                lookup_valid,
    output logic [ID_WIDTH-1:0] lookup_id,
    output logic [CNT_W-1:0]    count
);

    slot_t            table_reg [MAX_OUTSTANDING];
    logic [CNT_W-1:0] count_reg;
    logic             free_hit;

    // Lowest free index wins; scanning downward lets the lowest overwrite.
    always_comb begin
        alloc_ok  = 1'b0;
        alloc_tag = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!table_reg[i].valid) begin
                alloc_ok  = 1'b1;
                alloc_tag = TAG_W'(i);
            end
        end
    end

    // Only a valid slot can be freed, so the count never underflows.
    assign free_hit     = free_en && table_reg[free_tag].valid;
    assign lookup_valid = table_reg[lookup_tag].valid;
    assign lookup_id    = ID_WIDTH'(table_reg[lookup_tag].id);
    assign count        = count_reg;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                table_reg[i] <= '0;
            end
            count_reg <= '0;
        end else begin
            // Allocation targets an invalid slot and freeing a valid one,
            // so the two writes never hit the same entry.
            if (free_hit) begin
                table_reg[free_tag].valid <= 1'b0;
            end
            if (alloc_en && alloc_ok) begin
                table_reg[alloc_tag].valid <= 1'b1;
                table_reg[alloc_tag].id    <= SLOT_ID_MAX'(alloc_id);
            end
            count_reg <= count_reg + CNT_W'(alloc_en && alloc_ok) - CNT_W'(free_hit);
        end
    end

endmodule

// File: rtl/axi_grid_sni_rd.sv
// Read-path slave network interface between a local AXI master and the grid.
//   s_ar_* : AXI AR from the master      s_r_* : AXI R back to the master
//   g_ar_* : tagged AR flit to the grid  g_r_* : tagged R flits from the grid
//   outstanding_o  : number of reads in flight on the grid
//   err_spurious_o : one-cycle pulse after an R flit with an unallocated tag
// Unmapped addresses are answered locally with a DECERR burst.
module axi_grid_sni_rd
    import axi_grid_sni_pkg::*;
#(
    parameter int  ADDR_WIDTH      = 32,
    parameter int  DATA_WIDTH      = 64,
    parameter int  ID_WIDTH        = 4,
    parameter int  GRID_ID_WIDTH   = 4,
    parameter logic [GRID_ID_WIDTH-1:0] NI_ID = '0,
    parameter int  NUM_REGIONS     = 4,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0]    REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0]    REGION_MASK = '0,
    parameter logic [NUM_REGIONS*GRID_ID_WIDTH-1:0] REGION_DEST = '0,
    parameter int  MAX_OUTSTANDING = 8,
    localparam int TAG_W           = $clog2(MAX_OUTSTANDING),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic                     s_ar_valid_i,
    output logic                     s_ar_ready_o,
    input  logic [ID_WIDTH-1:0]      s_ar_id_i,
    input  logic [ADDR_WIDTH-1:0]    s_ar_addr_i,
    input  logic [7:0]               s_ar_len_i,
    input  logic [2:0]               s_ar_size_i,
    input  logic [1:0]               s_ar_burst_i,
    output logic                     s_r_valid_o,
    input  logic                     s_r_ready_i,
    output logic [ID_WIDTH-1:0]      s_r_id_o,
    output logic [DATA_WIDTH-1:0]    s_r_data_o,
    output logic [1:0]               s_r_resp_o,
    output logic                     s_r_last_o,
    output logic                     g_ar_valid_o,
    input  logic                     g_ar_ready_i,
    output logic [GRID_ID_WIDTH-1:0] g_ar_dst_o,
    output logic [GRID_ID_WIDTH-1:0] g_ar_src_o,
    output logic [TAG_W-1:0]         g_ar_tag_o,
    output logic [ADDR_WIDTH-1:0]    g_ar_addr_o,
    output logic [7:0]               g_ar_len_o,
    output logic [2:0]               g_ar_size_o,
    output logic [1:0]               g_ar_burst_o,
    input  logic                     g_r_valid_i,
    output logic                     g_r_ready_o,
    input  logic [TAG_W-1:0]         g_r_tag_i,
    input  logic [DATA_WIDTH-1:0]    g_r_data_i,
    input  logic [1:0]               g_r_resp_i,
    input  logic                     g_r_last_i,
    output logic [CNT_W-1:0]         outstanding_o,
    output logic                     err_spurious_o
);

    logic [NUM_REGIONS-1:0]   hit_vec;
    logic                     hit_any;
    logic [GRID_ID_WIDTH-1:0] hit_dst;
    logic                     alloc_ok, alloc_en, slot_valid;
    logic [TAG_W-1:0]         alloc_tag;
    logic [ID_WIDTH-1:0]      slot_id;

    r_owner_e                 owner_reg;
    err_state_e               err_state_reg;
    logic [ID_WIDTH-1:0]      err_id_reg;
    logic [7:0]               err_len_reg, err_beat_reg;
    logic                     spurious_reg;

    logic spurious, grid_take, grid_sel, err_sel, err_last;
    logic grid_hs, grid_last_hs, err_hs, err_last_hs;

    // ---------------- address decode ----------------
    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_dec
            assign hit_vec[gi] = region_match(
                DEC_ADDR_MAX'(s_ar_addr_i),
                DEC_ADDR_MAX'(REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                DEC_ADDR_MAX'(REGION_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]));
        end
    endgenerate

    always_comb begin
        hit_any = 1'b0;
        hit_dst = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_dst = REGION_DEST[i*GRID_ID_WIDTH +: GRID_ID_WIDTH];
            end
        end
    end

    // ---------------- AR path ----------------
    assign g_ar_valid_o = s_ar_valid_i && hit_any && alloc_ok;
    assign s_ar_ready_o = hit_any ? (g_ar_ready_i && alloc_ok) : (err_state_reg == ERR_IDLE);
    assign alloc_en     = s_ar_valid_i && s_ar_ready_o && hit_any;
    assign g_ar_dst_o   = hit_dst;
    assign g_ar_src_o   = NI_ID;
    assign g_ar_tag_o   = alloc_tag;
    assign g_ar_addr_o  = s_ar_addr_i;
    assign g_ar_len_o   = s_ar_len_i;
    assign g_ar_size_o  = s_ar_size_i;
    assign g_ar_burst_o = s_ar_burst_i;

    axi_grid_sni_slot_table #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .ID_WIDTH        (ID_WIDTH)
    ) u_slot_table (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .alloc_en     (alloc_en),
        .alloc_id     (s_ar_id_i),
        .alloc_ok     (alloc_ok),
        .alloc_tag    (alloc_tag),
        .free_en      (grid_last_hs),
        .free_tag     (g_r_tag_i),
        .lookup_tag   (g_r_tag_i),
        .lookup_valid (slot_valid),
        .lookup_id    (slot_id),
        .count        (outstanding_o)
    );

    // ---------------- R path ----------------
    // A flit for an unallocated tag is swallowed without touching ownership.
    assign spurious  = g_r_valid_i && !slot_valid;
    assign grid_take = g_r_valid_i && slot_valid;
    assign grid_sel  = (owner_reg == R_GRID) || (owner_reg == R_NONE && grid_take);
    assign err_sel   = (owner_reg == R_ERR) ||
                       (owner_reg == R_NONE && !grid_take && err_state_reg == ERR_RESP);
    assign err_last  = (err_beat_reg == err_len_reg);

    assign grid_hs      = grid_sel && grid_take && s_r_ready_i;
    assign grid_last_hs = grid_hs && g_r_last_i;
    assign err_hs       = err_sel && s_r_ready_i;
    assign err_last_hs  = err_hs && err_last;

    assign g_r_ready_o    = spurious || (grid_sel && s_r_ready_i);
    assign err_spurious_o = spurious_reg;

    always_comb begin
        s_r_valid_o = 1'b0;
        s_r_id_o    = slot_id;
        s_r_data_o  = g_r_data_i;
        s_r_resp_o  = g_r_resp_i;
        s_r_last_o  = g_r_last_i;
        if (grid_sel) begin
            s_r_valid_o = grid_take;
        end else if (err_sel) begin
            s_r_valid_o = 1'b1;
            s_r_id_o    = err_id_reg;
            s_r_data_o  = '0;
            s_r_resp_o  = RESP_DECERR;
            s_r_last_o  = err_last;
        end
    end

    // Owner is claimed on the first beat and released on the last-beat
    // handshake, so grid and error bursts never interleave.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            owner_reg    <= R_NONE;
            spurious_reg <= 1'b0;
        end else begin
            spurious_reg <= spurious;
            case (owner_reg)
                R_NONE: begin
                    if (grid_take) begin
                        owner_reg <= grid_last_hs ? R_NONE : R_GRID;
                    end else if (err_state_reg == ERR_RESP) begin
                        owner_reg <= err_last_hs ? R_NONE : R_ERR;
                    end
                end
                R_GRID:  if (grid_last_hs) owner_reg <= R_NONE;
                R_ERR:   if (err_last_hs)  owner_reg <= R_NONE;
                default: owner_reg <= R_NONE;
            endcase
        end
    end

    // Local DECERR responder: len+1 beats, never holds a slot.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_state_reg <= ERR_IDLE;
            err_id_reg    <= '0;
            err_len_reg   <= '0;
            err_beat_reg  <= '0;
        end else begin
            case (err_state_reg)
                ERR_IDLE: begin
                    if (s_ar_valid_i && !hit_any) begin
                        err_state_reg <= ERR_RESP;
                        err_id_reg    <= s_ar_id_i;
                        err_len_reg   <= s_ar_len_i;
                        err_beat_reg  <= '0;
                    end
                end
                ERR_RESP: begin
                    if (err_hs) begin
                        if (err_last) begin
                            err_state_reg <= ERR_IDLE;
                        end else begin
                            err_beat_reg <= err_beat_reg + 8'd1;
                        end
                    end
                end
                default: err_state_reg <= ERR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_grid_sni_rd.sv
module tb_axi_grid_sni_rd;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        s_ar_valid_i, s_ar_ready_o;
    logic [3:0]  s_ar_id_i;
    logic [31:0] s_ar_addr_i;
    logic [7:0]  s_ar_len_i;
    logic [2:0]  s_ar_size_i;
    logic [1:0]  s_ar_burst_i;
    logic        s_r_valid_o, s_r_ready_i;
    logic [3:0]  s_r_id_o;
    logic [63:0] s_r_data_o;
    logic [1:0]  s_r_resp_o;
    logic        s_r_last_o;
    logic        g_ar_valid_o, g_ar_ready_i;
    logic [3:0]  g_ar_dst_o, g_ar_src_o;
    logic [2:0]  g_ar_tag_o;
    logic [31:0] g_ar_addr_o;
    logic [7:0]  g_ar_len_o;
    logic [2:0]  g_ar_size_o;
    logic [1:0]  g_ar_burst_o;
    logic        g_r_valid_i, g_r_ready_o;
    logic [2:0]  g_r_tag_i;
    logic [63:0] g_r_data_i;
    logic [1:0]  g_r_resp_i;
    logic        g_r_last_i;
    logic [3:0]  outstanding_o;
    logic        err_spurious_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    axi_grid_sni_rd #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (64),
        .ID_WIDTH        (4),
        .GRID_ID_WIDTH   (4),
        .NI_ID           (4'd2),
        .NUM_REGIONS     (2),
        .REGION_BASE     ({32'h1000_0000, 32'h2000_0000}),
        .REGION_MASK     ({32'hF000_0000, 32'hF000_0000}),
        .REGION_DEST     ({4'd5, 4'd3}),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .s_ar_valid_i   (s_ar_valid_i),
        .s_ar_ready_o   (s_ar_ready_o),
        .s_ar_id_i      (s_ar_id_i),
        .s_ar_addr_i    (s_ar_addr_i),
        .s_ar_len_i     (s_ar_len_i),
        .s_ar_size_i    (s_ar_size_i),
        .s_ar_burst_i   (s_ar_burst_i),
        .s_r_valid_o    (s_r_valid_o),
        .s_r_ready_i    (s_r_ready_i),
        .s_r_id_o       (s_r_id_o),
        .s_r_data_o     (s_r_data_o),
        .s_r_resp_o     (s_r_resp_o),
        .s_r_last_o     (s_r_last_o),
        .g_ar_valid_o   (g_ar_valid_o),
        .g_ar_ready_i   (g_ar_ready_i),
        .g_ar_dst_o     (g_ar_dst_o),
        .g_ar_src_o     (g_ar_src_o),
        .g_ar_tag_o     (g_ar_tag_o),
        .g_ar_addr_o    (g_ar_addr_o),
        .g_ar_len_o     (g_ar_len_o),
        .g_ar_size_o    (g_ar_size_o),
        .g_ar_burst_o   (g_ar_burst_o),
        .g_r_valid_i    (g_r_valid_i),
        .g_r_ready_o    (g_r_ready_o),
        .g_r_tag_i      (g_r_tag_i),
        .g_r_data_i     (g_r_data_i),
        .g_r_resp_i     (g_r_resp_i),
        .g_r_last_i     (g_r_last_i),
        .outstanding_o  (outstanding_o),
        .err_spurious_o (err_spurious_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_ni      = 1'b0;
        s_ar_valid_i = 1'b0;
        s_ar_id_i    = 4'd0;
        s_ar_addr_i  = 32'h1000_0000;
        s_ar_len_i   = 8'd0;
        s_ar_size_i  = 3'd3;
        s_ar_burst_i = 2'b01;
        s_r_ready_i  = 1'b0;
        g_ar_ready_i = 1'b0;
        g_r_valid_i  = 1'b0;
        g_r_tag_i    = 3'd0;
        g_r_data_i   = 64'd0;
        g_r_resp_i   = 2'b00;
        g_r_last_i   = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_s_ar_ready", 64'(s_ar_ready_o), 64'(0));
        chk("rst_g_ar_valid", 64'(g_ar_valid_o), 64'(0));
        chk("rst_s_r_valid", 64'(s_r_valid_o), 64'(0));
        chk("rst_g_r_ready", 64'(g_r_ready_o), 64'(0));
        chk("rst_outstanding", 64'(outstanding_o), 64'(0));
        chk("rst_err_spurious", 64'(err_spurious_o), 64'(0));
        $display("reset checked");
        @(negedge clk_i);
        arst_ni = 1'b1; g_ar_ready_i = 1'b1; s_r_ready_i = 1'b1;

        // ---- mapped AR and 4-beat grid response ----
        @(negedge clk_i);
        s_ar_valid_i = 1'b1; s_ar_id_i = 4'd3; s_ar_addr_i = 32'h1000_0040; s_ar_len_i = 8'd3;
        #1;
        chk("t1_g_ar_valid", 64'(g_ar_valid_o), 64'(1));
        chk("t1_s_ar_ready", 64'(s_ar_ready_o), 64'(1));
        chk("t1_dst", 64'(g_ar_dst_o), 64'(5));
        chk("t1_src", 64'(g_ar_src_o), 64'(2));
        chk("t1_tag", 64'(g_ar_tag_o), 64'(0));
        chk("t1_addr", 64'(g_ar_addr_o), 64'h1000_0040);
        chk("t1_len", 64'(g_ar_len_o), 64'(3));
        @(posedge clk_i); #1;
        chk("t1_outstanding", 64'(outstanding_o), 64'(1));
        $display("AR id=3 tag=%0d dst=%0d", g_ar_tag_o, g_ar_dst_o);
        @(negedge clk_i);
        s_ar_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_i);
            g_r_valid_i = 1'b1; g_r_tag_i = 3'd0; g_r_data_i = 64'hA0 + 64'(b); g_r_last_i = (b == 3);
            #1;
            chk("t1_r_valid", 64'(s_r_valid_o), 64'(1));
            chk("t1_r_id", 64'(s_r_id_o), 64'(3));
            chk("t1_r_data", s_r_data_o, 64'hA0 + 64'(b));
            chk("t1_r_last", 64'(s_r_last_o), 64'(b == 3));
            chk("t1_g_r_ready", 64'(g_r_ready_o), 64'(1));
            $display("R beat %0d id=%0d data=%0h last=%0d", b, s_r_id_o, s_r_data_o, s_r_last_o);
        end
        @(negedge clk_i);
        g_r_valid_i = 1'b0; g_r_last_i = 1'b0;
        #1;
        chk("t1_outstanding_end", 64'(outstanding_o), 64'(0));
        chk("t1_r_idle", 64'(s_r_valid_o), 64'(0));

        // ---- fill all 8 slots, stall, free tag 5, re-allocate ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            s_ar_valid_i = 1'b1; s_ar_id_i = 4'(i); s_ar_addr_i = 32'h1000_0100 + 32'(i * 64); s_ar_len_i = 8'd0;
            #1;
            chk("t2_tag", 64'(g_ar_tag_o), 64'(i));
            chk("t2_g_ar_valid", 64'(g_ar_valid_o), 64'(1));
            $display("AR id=%0d tag=%0d", i, g_ar_tag_o);
        end
        @(negedge clk_i);
        s_ar_id_i = 4'hA;
        #1;
        chk("t2_stall_ready", 64'(s_ar_ready_o), 64'(0));
        chk("t2_stall_valid", 64'(g_ar_valid_o), 64'(0));
        chk("t2_full_count", 64'(outstanding_o), 64'(8));
        g_r_valid_i = 1'b1; g_r_tag_i = 3'd5; g_r_last_i = 1'b1; g_r_data_i = 64'h55;
        #1;
        chk("t2_ret5_id", 64'(s_r_id_o), 64'(5));
        chk("t2_ret5_valid", 64'(s_r_valid_o), 64'(1));
        chk("t2_ret5_same_cycle_ready", 64'(s_ar_ready_o), 64'(0));
        @(negedge clk_i);
        g_r_valid_i = 1'b0; g_r_last_i = 1'b0;
        #1;
        chk("t2_realloc_ready", 64'(s_ar_ready_o), 64'(1));
        chk("t2_realloc_tag", 64'(g_ar_tag_o), 64'(5));
        chk("t2_count_after_free", 64'(outstanding_o), 64'(7));
        $display("AR id=10 tag=%0d after free", g_ar_tag_o);
        @(negedge clk_i);
        s_ar_valid_i = 1'b0;
        #1;
        chk("t2_count_refill", 64'(outstanding_o), 64'(8));
        for (int t = 0; t < 8; t++) begin
            @(negedge clk_i);
            g_r_valid_i = 1'b1; g_r_tag_i = 3'(t); g_r_last_i = 1'b1; g_r_data_i = 64'(t);
            #1;
            chk("t2_drain_id", 64'(s_r_id_o), (t == 5) ? 64'hA : 64'(t));
            $display("R tag=%0d id=%0d", t, s_r_id_o);
        end
        @(negedge clk_i);
        g_r_valid_i = 1'b0; g_r_last_i = 1'b0;
        #1;
        chk("t2_drained", 64'(outstanding_o), 64'(0));

        // ---- spurious tag ----
        @(negedge clk_i);
        g_r_valid_i = 1'b1; g_r_tag_i = 3'd6; g_r_last_i = 1'b1;
        #1;
        chk("t5_g_r_ready", 64'(g_r_ready_o), 64'(1));
        chk("t5_s_r_valid", 64'(s_r_valid_o), 64'(0));
        @(posedge clk_i); #1;
        chk("t5_pulse_high", 64'(err_spurious_o), 64'(1));
        @(negedge clk_i);
        g_r_valid_i = 1'b0; g_r_last_i = 1'b0;
        @(posedge clk_i); #1;
        chk("t5_pulse_low", 64'(err_spurious_o), 64'(0));
        chk("t5_count", 64'(outstanding_o), 64'(0));
        $display("spurious tag 6 dropped");

        // ---- unmapped AR -> DECERR burst ----
        @(negedge clk_i);
        s_ar_valid_i = 1'b1; s_ar_addr_i = 32'hF000_0000; s_ar_len_i = 8'd3; s_ar_id_i = 4'd9;
        #1;
        chk("t3_ar_ready", 64'(s_ar_ready_o), 64'(1));
        chk("t3_g_ar_valid", 64'(g_ar_valid_o), 64'(0));
        @(negedge clk_i);
        s_ar_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk_i);
            #1;
            chk("t3_valid", 64'(s_r_valid_o), 64'(1));
            chk("t3_id", 64'(s_r_id_o), 64'(9));
            chk("t3_resp", 64'(s_r_resp_o), 64'(3));
            chk("t3_data", s_r_data_o, 64'd0);
            chk("t3_last", 64'(s_r_last_o), 64'(b == 3));
            chk("t3_no_g_ar", 64'(g_ar_valid_o), 64'(0));
            $display("DECERR beat %0d id=%0d last=%0d", b, s_r_id_o, s_r_last_o);
        end
        @(negedge clk_i); #1;
        chk("t3_done", 64'(s_r_valid_o), 64'(0));
        chk("t3_count", 64'(outstanding_o), 64'(0));

        // ---- grid and error bursts pending together ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            s_ar_valid_i = 1'b1; s_ar_id_i = 4'(i + 1); s_ar_addr_i = 32'h2000_0010; s_ar_len_i = 8'd1;
            #1;
            chk("t4_tag", 64'(g_ar_tag_o), 64'(i));
            chk("t4_dst", 64'(g_ar_dst_o), 64'(3));
        end
        @(negedge clk_i);
        s_ar_addr_i = 32'hF000_0000; s_ar_id_i = 4'd7; s_ar_len_i = 8'd1;
        #1;
        chk("t4_err_ar_ready", 64'(s_ar_ready_o), 64'(1));
        @(negedge clk_i);
        s_ar_valid_i = 1'b0; s_ar_addr_i = 32'h1000_0000;
        g_r_valid_i = 1'b1; g_r_tag_i = 3'd2; g_r_data_i = 64'hB0; g_r_last_i = 1'b0; g_r_resp_i = 2'b00;
        #1;
        chk("t4_g0_valid", 64'(s_r_valid_o), 64'(1));
        chk("t4_g0_id", 64'(s_r_id_o), 64'(3));
        chk("t4_g0_resp", 64'(s_r_resp_o), 64'(0));
        chk("t4_g0_data", s_r_data_o, 64'hB0);
        $display("grid beat 0 tag=2 id=%0d", s_r_id_o);
        @(negedge clk_i);
        g_r_data_i = 64'hB1; g_r_last_i = 1'b1;
        #1;
        chk("t4_g1_id", 64'(s_r_id_o), 64'(3));
        chk("t4_g1_resp", 64'(s_r_resp_o), 64'(0));
        chk("t4_g1_last", 64'(s_r_last_o), 64'(1));
        $display("grid beat 1 tag=2 id=%0d last", s_r_id_o);
        @(negedge clk_i);
        g_r_valid_i = 1'b0; g_r_last_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (b > 0) @(negedge clk_i);
            #1;
            chk("t4_e_valid", 64'(s_r_valid_o), 64'(1));
            chk("t4_e_id", 64'(s_r_id_o), 64'(7));
            chk("t4_e_resp", 64'(s_r_resp_o), 64'(3));
            chk("t4_e_last", 64'(s_r_last_o), 64'(b == 1));
            $display("DECERR beat %0d id=%0d", b, s_r_id_o);
        end
        @(negedge clk_i); #1;
        chk("t4_idle", 64'(s_r_valid_o), 64'(0));
        chk("t4_count", 64'(outstanding_o), 64'(2));

        // ---- reset in the middle of an error burst ----
        @(negedge clk_i);
        s_ar_valid_i = 1'b1; s_ar_addr_i = 32'hF000_0000; s_ar_len_i = 8'd7; s_ar_id_i = 4'd4;
        #1;
        chk("t6_ar_ready", 64'(s_ar_ready_o), 64'(1));
        @(negedge clk_i);
        s_ar_valid_i = 1'b0; s_ar_addr_i = 32'h1000_0000;
        #1;
        chk("t6_burst_on", 64'(s_r_valid_o), 64'(1));
        chk("t6_burst_id", 64'(s_r_id_o), 64'(4));
        @(posedge clk_i);
        #2;
        arst_ni = 1'b0;
        #1;
        chk("t6_rst_r_valid", 64'(s_r_valid_o), 64'(0));
        chk("t6_rst_count", 64'(outstanding_o), 64'(0));
        $display("reset asserted mid-burst");
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
        g_r_valid_i = 1'b1; g_r_tag_i = 3'd1; g_r_last_i = 1'b1;
        #1;
        chk("t6_late_ready", 64'(g_r_ready_o), 64'(1));
        chk("t6_late_r_valid", 64'(s_r_valid_o), 64'(0));
        @(negedge clk_i);
        g_r_valid_i = 1'b0; g_r_last_i = 1'b0;
        s_ar_valid_i = 1'b1; s_ar_id_i = 4'd6; s_ar_len_i = 8'd0;
        #1;
        chk("t6_late_pulse", 64'(err_spurious_o), 64'(1));
        chk("t6_new_tag", 64'(g_ar_tag_o), 64'(0));
        chk("t6_new_valid", 64'(g_ar_valid_o), 64'(1));
        @(negedge clk_i);
        s_ar_valid_i = 1'b0;
        #1;
        chk("t6_new_count", 64'(outstanding_o), 64'(1));
        $display("AR after reset id=6 accepted");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
